// File: rtl/inner_product_engine.sv
// Fixed-point inner-product sequencer: walks idx 0..dim over external operand
// memories, multiplies each returned pair, and accumulates into a wrapping register.
module inner_product_engine #(
  parameter int nBits = 32,
  parameter int FRAC  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             addsub,
  input  logic [nBits-1:0] dim,
  input  logic [nBits-1:0] resetvalue,
  input  logic [nBits-1:0] a_data,
  input  logic [nBits-1:0] b_data,
  output logic [nBits-1:0] idx,
  output logic             rd_en,
  output logic [nBits-1:0] result,
  output logic             endflag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [nBits-1:0] ONE = 1;

  state_t             state_q, state_d;
  logic [nBits-1:0]   idx_q, idx_d;
  logic               rd_en_q, rd_en_d;
  logic [nBits-1:0]   acc_q, acc_d;
  logic [nBits-1:0]   result_q, result_d;
  logic               endflag_q, endflag_d;
  logic               busy_q, busy_d;
  logic [nBits-1:0]   dim_q, dim_d;
  logic               addsub_q, addsub_d;
  logic               vld_q, vld_d;

  logic signed [2*nBits-1:0] prod;
  logic [nBits-1:0]          p;

  always_comb begin
    prod = (2*nBits)'($signed(a_data)) * (2*nBits)'($signed(b_data));
    p    = nBits'(prod >>> FRAC);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_en_d   = rd_en_q;
    acc_d     = acc_q;
    result_d  = result_q;
    endflag_d = 1'b0;
    busy_d    = busy_q;
    dim_d     = dim_q;
    addsub_d  = addsub_q;
    // operands arrive one cycle after the read, so valid is rd_en delayed once
    vld_d     = rd_en_q;

    if (vld_q) acc_d = addsub_q ? acc_q + p : acc_q - p;

    case (state_q)
      IDLE: begin
        // busy stays up through the endflag cycle, then drops unless restarted
        busy_d = start;
        if (start) begin
          dim_d    = dim;
          addsub_d = addsub;
          acc_d    = resetvalue;
          idx_d    = '0;
          rd_en_d  = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (idx_q == dim_q) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        result_d  = acc_q;
        endflag_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
      endflag_q <= 1'b0;
      busy_q    <= 1'b0;
      dim_q     <= '0;
      addsub_q  <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      endflag_q <= endflag_d;
      busy_q    <= busy_d;
      dim_q     <= dim_d;
      addsub_q  <= addsub_d;
      vld_q     <= vld_d;
    end
  end

  assign idx     = idx_q;
  assign rd_en   = rd_en_q;
  assign result  = result_q;
  assign endflag = endflag_q;
  assign busy    = busy_q;

endmodule
